// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared types and register-map constants
// for the memory-mapped LED PWM/blink controller.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_PWM   = 2'd2,
        LED_BLINK = 2'd3
    } led_mode_e;

    localparam int ADDR_CTRL     = 0;
    localparam int ADDR_PRESCALE = 1;
    localparam int ADDR_CH_BASE  = 4;

    localparam int CFG_MODE_LSB = 0;
    localparam int CFG_MODE_W   = 2;
    localparam int CFG_DUTY_LSB = 2;
    localparam int CFG_HALF_LSB = 16;
    localparam int CFG_HALF_W   = 16;

endpackage

// File: rtl/led_channel.sv
// led_channel: one LED's config registers, duty shadow,
// blink frame counter/phase and registered output.
module led_channel
    import led_ctrl_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  tick,
    input  logic                  frame_end,
    input  logic [PWM_BITS-1:0]   pwm_cnt,
    input  logic                  cfg_we,
    input  logic [CFG_MODE_W-1:0] mode_in,
    input  logic [PWM_BITS-1:0]   duty_in,
    input  logic [CFG_HALF_W-1:0] half_in,
    output logic [31:0]           cfg,
    output logic                  led
);

    led_mode_e             mode;
    logic [PWM_BITS-1:0]   duty;
    logic [PWM_BITS-1:0]   shadow;
    logic [CFG_HALF_W-1:0] half;
    logic [CFG_HALF_W-1:0] fcnt;
    logic [CFG_HALF_W-1:0] hp_m1;
    logic                  phase;
    logic                  frame_adv;
    logic                  led_d;

    assign frame_adv = tick & frame_end;
    assign hp_m1     = (half == '0) ? '0 : half - 1'b1;

    // Configuration registers written from the bus
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode <= LED_OFF;
            duty <= '0;
            half <= '0;
        end else if (cfg_we) begin
            mode <= led_mode_e'(mode_in);
            duty <= duty_in;
            half <= half_in;
        end
    end

    // Duty shadow: follows duty while idle, else only at frame boundaries
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow <= '0;
        end else if (!enable || frame_adv) begin
            shadow <= duty;
        end
    end

    // Blink frame counter and phase toggle
    always_ff @(posedge clk) begin
        if (!reset || !enable || cfg_we) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (frame_adv) begin
            if (fcnt >= hp_m1) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // Next LED value from mode
    always_comb begin
        led_d = 1'b0;
        if (enable) begin
            unique case (mode)
                LED_OFF:   led_d = 1'b0;
                LED_ON:    led_d = 1'b1;
                LED_PWM:   led_d = (pwm_cnt < shadow);
                LED_BLINK: led_d = phase;
            endcase
        end
    end

    // Registered LED drive
    always_ff @(posedge clk) begin
        if (!reset) begin
            led <= 1'b0;
        end else begin
            led <= led_d;
        end
    end

    // Read-back word, unused bits zero
    always_comb begin
        cfg = '0;
        cfg[CFG_MODE_LSB +: CFG_MODE_W] = mode;
        cfg[CFG_DUTY_LSB +: PWM_BITS]   = duty;
        cfg[CFG_HALF_LSB +: CFG_HALF_W] = half;
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// led_pwm_ctrl: register decode, shared prescaler and PWM
// frame counter, read mux and per-LED channel instances.
module led_pwm_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS   = 4,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE_W = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                we,
    input  logic [31:0]         wdata,
    input  logic                re,
    output logic [31:0]         rdata,
    output logic [NUM_LEDS-1:0] led
);

    logic                  en;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic                  tick;
    logic                  frame_end;
    logic                  ctrl_we;
    logic                  pre_we;
    logic [NUM_LEDS-1:0]   cfg_we;
    logic [31:0]           cfg [NUM_LEDS];
    logic [31:0]           rd_mux;

    assign ctrl_we   = we && (addr == ADDR_W'(ADDR_CTRL));
    assign pre_we    = we && (addr == ADDR_W'(ADDR_PRESCALE));
    assign tick      = en && (pre_cnt == prescale);
    assign frame_end = tick && (&pwm_cnt);

    // CTRL and PRESCALE registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            en       <= 1'b0;
            prescale <= '0;
        end else begin
            if (ctrl_we) en <= wdata[0];
            if (pre_we)  prescale <= wdata[PRESCALE_W-1:0];
        end
    end

    // Prescaler: counts 0..prescale, cleared on PRESCALE write
    always_ff @(posedge clk) begin
        if (!reset || !en || pre_we || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // PWM frame counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!reset || !en) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        assign cfg_we[i] = we && (addr == ADDR_W'(ADDR_CH_BASE + i));

        led_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .enable    (en),
            .tick      (tick),
            .frame_end (frame_end),
            .pwm_cnt   (pwm_cnt),
            .cfg_we    (cfg_we[i]),
            .mode_in   (wdata[CFG_MODE_LSB +: CFG_MODE_W]),
            .duty_in   (wdata[CFG_DUTY_LSB +: PWM_BITS]),
            .half_in   (wdata[CFG_HALF_LSB +: CFG_HALF_W]),
            .cfg       (cfg[i]),
            .led       (led[i])
        );
    end

    // Read mux; unmapped addresses return zero
    always_comb begin
        rd_mux = '0;
        if (addr == ADDR_W'(ADDR_CTRL)) begin
            rd_mux = {31'b0, en};
        end else if (addr == ADDR_W'(ADDR_PRESCALE)) begin
            rd_mux = 32'(prescale);
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (addr == ADDR_W'(ADDR_CH_BASE + i)) rd_mux = cfg[i];
            end
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_mux;
        end
    end

endmodule

// File: doc/led_pwm_ctrl.md
# led_pwm_ctrl

Memory-mapped LED controller for the Arty S7 board top, replacing the direct CPU-to-`led` connection. It drives `NUM_LEDS` outputs, each independently set to off, on, PWM brightness or blink mode. A shared prescaler and PWM frame counter time all channels. The CPU programs it through a single-cycle register bus decoded from the data address space.

## Interface
- `NUM_LEDS`, 4: number of LED channels (1..8)
- `PWM_BITS`, 8: PWM counter/duty width (1..14)
- `PRESCALE_W`, 16: prescaler register width (1..32)
- `ADDR_W`, 4: word-index address width
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-low reset
- `addr` in `ADDR_W`: register word index
- `we` in 1: write strobe, one cycle
- `wdata` in 32: write data
- `re` in 1: read strobe, one cycle
- `rdata` out 32: read data, registered
- `led` out `NUM_LEDS`: LED drive, registered, active-high

## Operation
- Register map (word index):
  - 0 `CTRL`: bit0 = global enable.
  - 1 `PRESCALE`: bits [`PRESCALE_W`-1:0].
  - 4+n `CH_CFG[n]`:
    - [1:0] mode: 0 OFF, 1 ON, 2 PWM, 3 BLINK.
    - [`PWM_BITS`+1:2] duty.
    - [31:16] blink half-period, in PWM frames.
- Unmapped reads return 0. Unmapped writes are ignored. Unused register bits read 0.
- Prescaler:
  - `pre_cnt` counts 0..`PRESCALE`.
  - `tick` is asserted in the cycle `pre_cnt == PRESCALE`, then `pre_cnt` returns to 0. The divide ratio is `PRESCALE`+1; `PRESCALE`=0 gives a tick every cycle.
  - A write to `PRESCALE` clears `pre_cnt` in the same cycle.
- PWM counter:
  - `pwm_cnt` increments on `tick` and wraps from 2^`PWM_BITS`-1 to 0.
  - `frame_end` = `tick` && `pwm_cnt` is all ones.
- Duty shadowing:
  - Each channel holds a shadow duty.
  - The shadow loads from `CH_CFG` duty on `frame_end`, or immediately if enable=0.
  - Mid-frame duty writes therefore never glitch the output.
- Per-channel `led` next value:
  - OFF: 0.
  - ON: 1.
  - PWM: `pwm_cnt` < shadow duty. Duty 0 gives always 0; max duty gives on for (2^N-1)/2^N of the frame.
  - BLINK: `phase` bit.
- Blink mechanism:
  - A per-channel 16-bit frame counter increments on `frame_end`.
  - When it reaches half-period-1, it clears and `phase` toggles. Half-period 0 behaves as 1.
  - Writing `CH_CFG[n]` clears that channel's frame counter and `phase`.
- Global enable=0:
  - `pre_cnt`, `pwm_cnt`, all frame counters and phases are held at 0.
  - `led` = 0 regardless of mode; registers remain writable.
- Reset: all registers, counters, shadows, `phase`, `led` and `rdata` go to 0.
- Simultaneous `re` and `we` to the same address: `rdata` returns the pre-write value.

## Timing
- Write latency: a register updates at the `we` clock edge; `led` reflects ON/OFF changes 2 edges after the `we` edge (register, then output flop).
- Read: `rdata` is valid the cycle after `re`. It holds its value until the next `re`, and is not cleared.
- PWM period is (`PRESCALE`+1)·2^`PWM_BITS` cycles.
- Blink full period is 2·half-period PWM frames.
- `led` is a pure flop output, with no combinational path from `addr`/`wdata`.
- Reset asserted mid-frame: at the next edge all state is 0. The first `tick` after deassert occurs `PRESCALE`+1 cycles later (with enable set).

## Structure
- Package `led_ctrl_pkg` holds:
  - `led_mode_e` (OFF/ON/PWM/BLINK);
  - address constants `ADDR_CTRL`, `ADDR_PRESCALE`, `ADDR_CH_BASE`;
  - field-position constants for `CH_CFG`.
- Sub-module `led_channel`: one instance per LED. It contains the mode/duty/half-period registers, the shadow duty, the blink counter/phase and the output flop. Inputs are `tick`, `frame_end`, `pwm_cnt`, `enable` and the write strobe.
- The top contains the decode, `CTRL`/`PRESCALE`, prescaler, PWM counter and read mux.

## Test plan
- Reset, then read all registers: `rdata`=0; `led`=0; unmapped address 15 reads 0 after writing 0xFFFFFFFF to it.
- Write `CTRL`=1, `CH_CFG[0]`=1 (ON), `CH_CFG[1]`=0 → `led`[0]=1 exactly 2 edges after the write, `led`[1]=0.
- `PRESCALE`=0, `PWM_BITS`=8, ch2 PWM duty=64 → `led`[2] high for 64 of every 256 cycles; duty 0 gives never high; duty 255 gives high for 255 of 256 cycles.
- Mid-frame duty change 64→192 at `pwm_cnt`=100 → current frame keeps its 64-cycle high; the next frame shows 192.
- `PRESCALE`=1, ch3 BLINK half-period=2 → `led`[3] toggles every 2·512=1024 cycles; half-period 0 toggles every 512 cycles.
- Clear `CTRL`=0 mid-blink → `led`=0 next cycle; re-enable → blink restarts from phase 0; assert `reset` mid-frame → all outputs 0 next edge.
